// File: rtl/ram_burst_master_pkg.sv
// Shared types and helpers for the RAM burst master and its read FIFO.
package ram_burst_master_pkg;

    // Burst controller states; the write/read direction is carried by the state itself.
    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRead,
        StDrain,
        StDone
    } state_e;

    // Read-return FIFO depth; the read issue throttle is sized against this.
    localparam int unsigned CFifoDepth = 2;

    // Next sequential RAM address, wrapping to 0 above 2^i_width-1 (i_width <= 32).
    function automatic logic [31:0] f_next_addr(input logic [31:0] i_addr,
                                                input int unsigned i_width);
        logic [31:0] w_mask;
        w_mask = (i_width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << i_width) - 32'd1);
        return (i_addr + 32'd1) & w_mask;
    endfunction

endpackage

// File: rtl/ram_burst_rdfifo.sv
// Two-entry FIFO that buffers RAM read data ahead of the backpressured read stream.
module ram_burst_rdfifo
    import ram_burst_master_pkg::*;
#(
    parameter int unsigned CDataLen = 128
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_en,
    input  logic                i_push,
    input  logic [CDataLen-1:0] i_push_data,
    input  logic                i_pop,
    output logic [1:0]          o_occ,
    output logic [CDataLen-1:0] o_head,
    output logic                o_empty
);

    logic [CDataLen-1:0] r_mem [CFifoDepth];
    // One-bit pointers: the depth is fixed at two entries.
    logic                r_wr_ptr;
    logic                r_rd_ptr;
    logic [1:0]          r_count;

    // Pointer and occupancy tracking; push and pop may coincide.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_rst) begin
                r_wr_ptr <= 1'b0;
                r_rd_ptr <= 1'b0;
                r_count  <= 2'd0;
            end else begin
                if (i_push) r_wr_ptr <= !r_wr_ptr;
                if (i_pop)  r_rd_ptr <= !r_rd_ptr;
                case ({i_push, i_pop})
                    2'b10:   r_count <= r_count + 2'd1;
                    2'b01:   r_count <= r_count - 2'd1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Data storage needs no reset; occupancy says which entries are meaningful.
    always_ff @(posedge i_clk) begin
        if (i_en && !i_rst && i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Status and head word.
    always_comb begin
        o_occ   = r_count;
        o_empty = (r_count == 2'd0);
        o_head  = r_mem[r_rd_ptr];
    end

endmodule

// File: rtl/ram_burst_master.sv
// Burst initiator for a single-port RAM: one command at a time, write bursts from a
// stream, read bursts into a 2-deep FIFO feeding a backpressured stream.
// Optional running XOR checksum output ACsum when RAM_BURST_MASTER_CSUM_EN is defined.
module ram_burst_master
    import ram_burst_master_pkg::*;
#(
    parameter int unsigned CAddrLen = 13,
    parameter int unsigned CDataLen = 128,
    parameter int unsigned CLenLen  = 8
) (
    input  logic                AClkH,
    input  logic                AResetH,
    input  logic                AClkHEn,
    input  logic [CAddrLen-1:0] ACmdAddr,
    input  logic [CLenLen-1:0]  ACmdLen,
    input  logic                ACmdWr,
    input  logic                ACmdReq,
    output logic                ACmdAck,
    input  logic [CDataLen-1:0] AWrData,
    input  logic                AWrVld,
    output logic                AWrRdy,
    output logic [CDataLen-1:0] ARdData,
    output logic                ARdVld,
    input  logic                ARdRdy,
    output logic                ABusy,
    output logic                ADone,
    output logic [CAddrLen-1:0] RAddr,
    output logic [CDataLen-1:0] RMosi,
    input  logic [CDataLen-1:0] RMiso,
    output logic                RWrEn,
    output logic                RRdEn
`ifdef RAM_BURST_MASTER_CSUM_EN
    ,
    output logic [CDataLen-1:0] ACsum
`endif
);

    state_e              r_state;
    logic [CAddrLen-1:0] r_addr;
    logic [CLenLen-1:0]  r_count;
    logic                r_inflight;

    logic                w_run;
    logic [CAddrLen-1:0] w_addr_next;
    logic                w_last;
    logic                w_accept;
    logic                w_wr_fire;
    logic                w_rd_fire;
    logic                w_push;
    logic                w_pop;
    logic [2:0]          w_level;
    logic [1:0]          w_fifo_occ;
    logic [CDataLen-1:0] w_fifo_head;
    logic                w_fifo_empty;

    // Handshake decode; nothing fires while the clock is disabled or reset is applied.
    always_comb begin
        w_run       = AClkHEn && !AResetH;
        w_addr_next = CAddrLen'(f_next_addr(32'(r_addr), CAddrLen));
        w_last      = (r_count == CLenLen'(1));
        w_accept    = w_run && (r_state == StIdle) && ACmdReq;
        w_wr_fire   = w_run && (r_state == StWrite) && AWrVld;
        w_pop       = w_run && !w_fifo_empty && ARdRdy;
        w_push      = w_run && r_inflight;
        // Slots committed after this cycle's pop; counting the pop keeps reads at one per
        // cycle when the stream never stalls, without ever exceeding the FIFO depth.
        w_level     = 3'(w_fifo_occ) + 3'(r_inflight) - 3'(w_pop);
        w_rd_fire   = w_run && (r_state == StRead) && (r_count != '0)
                      && (w_level < 3'(CFifoDepth));
    end

    // Burst FSM with address/count tracking and the read in-flight flag.
    always_ff @(posedge AClkH) begin
        if (AClkHEn) begin
            if (AResetH) begin
                r_state    <= StIdle;
                r_addr     <= '0;
                r_count    <= '0;
                r_inflight <= 1'b0;
            end else begin
                r_inflight <= w_rd_fire;
                unique case (r_state)
                    StIdle: begin
                        if (ACmdReq) begin
                            r_addr  <= ACmdAddr;
                            r_count <= ACmdLen;
                            if (ACmdLen == '0) r_state <= StDone;
                            else if (ACmdWr)   r_state <= StWrite;
                            else               r_state <= StRead;
                        end
                    end
                    StWrite: begin
                        if (AWrVld) begin
                            r_addr  <= w_addr_next;
                            r_count <= r_count - CLenLen'(1);
                            if (w_last) r_state <= StDone;
                        end
                    end
                    StRead: begin
                        if (w_rd_fire) begin
                            r_addr  <= w_addr_next;
                            r_count <= r_count - CLenLen'(1);
                            if (w_last) r_state <= StDrain;
                        end
                    end
                    StDrain: begin
                        if (!r_inflight && w_fifo_empty) r_state <= StDone;
                    end
                    StDone: begin
                        r_state <= StIdle;
                    end
                    default: begin
                        r_state <= StIdle;
                    end
                endcase
            end
        end
    end

    // Returned RAM data lands in the FIFO the cycle after each read strobe.
    ram_burst_rdfifo #(
        .CDataLen (CDataLen)
    ) u_rdfifo (
        .i_clk       (AClkH),
        .i_rst       (AResetH),
        .i_en        (AClkHEn),
        .i_push      (w_push),
        .i_push_data (RMiso),
        .i_pop       (w_pop),
        .o_occ       (w_fifo_occ),
        .o_head      (w_fifo_head),
        .o_empty     (w_fifo_empty)
    );

    // Stream, status and RAM-side outputs.
    always_comb begin
        ACmdAck = w_accept;
        AWrRdy  = w_run && (r_state == StWrite);
        RWrEn   = w_wr_fire;
        RRdEn   = w_rd_fire;
        RAddr   = r_addr;
        RMosi   = (r_state == StWrite) ? AWrData : '0;
        ARdVld  = w_run && !w_fifo_empty;
        ARdData = w_fifo_empty ? '0 : w_fifo_head;
        ABusy   = (r_state == StWrite) || (r_state == StRead) || (r_state == StDrain);
        ADone   = w_run && (r_state == StDone);
    end

`ifdef RAM_BURST_MASTER_CSUM_EN
    logic [CDataLen-1:0] r_csum;

    // Running XOR of every word moved in the current or last burst; held after ADone.
    always_ff @(posedge AClkH) begin
        if (AClkHEn) begin
            if (AResetH)        r_csum <= '0;
            else if (w_accept)  r_csum <= '0;
            else if (w_wr_fire) r_csum <= r_csum ^ AWrData;
            else if (w_pop)     r_csum <= r_csum ^ w_fifo_head;
        end
    end

    assign ACsum = r_csum;
`endif

endmodule

// File: tb/tb_ram_burst_master.sv
// Directed self-checking bench for ram_burst_master with a behavioural one-cycle RAM.
module tb_ram_burst_master;

    localparam int unsigned CAddrLen = 13;
    localparam int unsigned CDataLen = 128;
    localparam int unsigned CLenLen  = 8;

    logic                AClkH = 1'b0;
    logic                AResetH;
    logic                AClkHEn;
    logic [CAddrLen-1:0] ACmdAddr;
    logic [CLenLen-1:0]  ACmdLen;
    logic                ACmdWr;
    logic                ACmdReq;
    logic                ACmdAck;
    logic [CDataLen-1:0] AWrData;
    logic                AWrVld;
    logic                AWrRdy;
    logic [CDataLen-1:0] ARdData;
    logic                ARdVld;
    logic                ARdRdy;
    logic                ABusy;
    logic                ADone;
    logic [CAddrLen-1:0] RAddr;
    logic [CDataLen-1:0] RMosi;
    logic [CDataLen-1:0] RMiso = '0;
    logic                RWrEn;
    logic                RRdEn;
`ifdef RAM_BURST_MASTER_CSUM_EN
    logic [CDataLen-1:0] ACsum;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [CDataLen-1:0] ram [0:(1 << CAddrLen) - 1];

    always #5 AClkH = ~AClkH;

    ram_burst_master #(
        .CAddrLen (CAddrLen),
        .CDataLen (CDataLen),
        .CLenLen  (CLenLen)
    ) dut (
        .AClkH    (AClkH),
        .AResetH  (AResetH),
        .AClkHEn  (AClkHEn),
        .ACmdAddr (ACmdAddr),
        .ACmdLen  (ACmdLen),
        .ACmdWr   (ACmdWr),
        .ACmdReq  (ACmdReq),
        .ACmdAck  (ACmdAck),
        .AWrData  (AWrData),
        .AWrVld   (AWrVld),
        .AWrRdy   (AWrRdy),
        .ARdData  (ARdData),
        .ARdVld   (ARdVld),
        .ARdRdy   (ARdRdy),
        .ABusy    (ABusy),
        .ADone    (ADone),
        .RAddr    (RAddr),
        .RMosi    (RMosi),
        .RMiso    (RMiso),
        .RWrEn    (RWrEn),
        .RRdEn    (RRdEn)
`ifdef RAM_BURST_MASTER_CSUM_EN
        ,
        .ACsum    (ACsum)
`endif
    );

    // Single-port RAM: write on strobe, read data one cycle after RRdEn, else 0.
    always @(posedge AClkH) begin
        if (AClkHEn) begin
            if (RWrEn) ram[RAddr] <= RMosi;
            RMiso <= RRdEn ? ram[RAddr] : '0;
        end
    end

    function automatic logic [CDataLen-1:0] wd(input int unsigned i);
        return {32'hCAFE_0000 + i, 32'h1234_5678, 32'h0000_0000, 32'h0000_00A0 + i};
    endfunction

    task automatic step();
        @(posedge AClkH);
        #1;
    endtask

    task automatic sample();
        @(negedge AClkH);
    endtask

    task automatic idle_inputs();
        AResetH  = 1'b0;
        AClkHEn  = 1'b1;
        ACmdAddr = '0;
        ACmdLen  = '0;
        ACmdWr   = 1'b0;
        ACmdReq  = 1'b0;
        AWrData  = '0;
        AWrVld   = 1'b0;
        ARdRdy   = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            sample();
            if (ADone) seen = 1'b1;
            step();
        end
    endtask

    // Preload helper: a full-rate write burst, returns one cycle after DONE.
    task automatic do_write(input logic [CAddrLen-1:0] addr, input int unsigned len,
                            input int unsigned base);
        ACmdReq = 1'b1; ACmdAddr = addr; ACmdLen = CLenLen'(len); ACmdWr = 1'b1;
        step();
        ACmdReq = 1'b0;
        AWrVld  = 1'b1;
        for (int i = 0; i < int'(len); i++) begin
            AWrData = wd(base + i);
            step();
        end
        AWrVld  = 1'b0;
        AWrData = '0;
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        AResetH = 1'b1;
        step();
        step();
        AResetH = 1'b0;
        sample();
        n_checks++;
        if ({ACmdAck, ABusy, ADone, ARdVld, AWrRdy, RWrEn, RRdEn} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, required 0000000",
                     {ACmdAck, ABusy, ADone, ARdVld, AWrRdy, RWrEn, RRdEn});
        end
        n_checks++;
        if (RAddr !== '0) begin
            n_fail++; $display("FAIL reset_raddr: got %h, required 0", RAddr);
        end
        n_checks++;
        if (RMosi !== '0) begin
            n_fail++; $display("FAIL reset_rmosi: got %h, required 0", RMosi);
        end
        n_checks++;
        if (ARdData !== '0) begin
            n_fail++; $display("FAIL reset_rddata: got %h, required 0", ARdData);
        end
        step();
    endtask

    task automatic test_write_burst();
        ACmdReq = 1'b1; ACmdAddr = 13'h0010; ACmdLen = 8'd4; ACmdWr = 1'b1;
        sample();
        n_checks++;
        if (ACmdAck !== 1'b1) begin
            n_fail++; $display("FAIL wr_ack: got %b, required 1", ACmdAck);
        end
        step();
        ACmdReq = 1'b0;
        for (int i = 0; i < 4; i++) begin
            AWrVld = 1'b1; AWrData = wd(i);
            sample();
            n_checks++;
            if ({AWrRdy, RWrEn, RRdEn, ABusy} !== 4'b1101) begin
                n_fail++;
                $display("FAIL wr_strobe[%0d]: got %b, required 1101", i,
                         {AWrRdy, RWrEn, RRdEn, ABusy});
            end
            n_checks++;
            if (RAddr !== 13'(16 + i)) begin
                n_fail++; $display("FAIL wr_addr[%0d]: got %h, required %h", i, RAddr, 13'(16 + i));
            end
            n_checks++;
            if (RMosi !== wd(i)) begin
                n_fail++; $display("FAIL wr_mosi[%0d]: got %h, required %h", i, RMosi, wd(i));
            end
            step();
        end
        AWrVld = 1'b0; AWrData = '0;
        sample();
        n_checks++;
        if ({ADone, ABusy, RWrEn} !== 3'b100) begin
            n_fail++; $display("FAIL wr_done: got %b, required 100", {ADone, ABusy, RWrEn});
        end
        step();
        sample();
        n_checks++;
        if (ADone !== 1'b0) begin
            n_fail++; $display("FAIL wr_done_pulse: got %b, required 0", ADone);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (ram[16 + i] !== wd(i)) begin
                n_fail++; $display("FAIL wr_ram[%0d]: got %h, required %h", i, ram[16 + i], wd(i));
            end
        end
        step();
    endtask

    task automatic test_read_burst();
        ARdRdy = 1'b1;
        ACmdReq = 1'b1; ACmdAddr = 13'h0010; ACmdLen = 8'd4; ACmdWr = 1'b0;
        sample();
        n_checks++;
        if (ACmdAck !== 1'b1) begin
            n_fail++; $display("FAIL rd_ack: got %b, required 1", ACmdAck);
        end
        step();
        ACmdReq = 1'b0;
        // Reads issue on cycles 1-4, data streams out on cycles 3-6, ADone on cycle 8.
        for (int c = 1; c <= 9; c++) begin
            sample();
            n_checks++;
            if (RRdEn !== (c >= 1 && c <= 4)) begin
                n_fail++; $display("FAIL rd_rrden[c%0d]: got %b", c, RRdEn);
            end
            if (c <= 4) begin
                n_checks++;
                if (RAddr !== 13'(16 + c - 1)) begin
                    n_fail++;
                    $display("FAIL rd_addr[c%0d]: got %h, required %h", c, RAddr, 13'(15 + c));
                end
            end
            n_checks++;
            if (ARdVld !== (c >= 3 && c <= 6)) begin
                n_fail++; $display("FAIL rd_vld[c%0d]: got %b", c, ARdVld);
            end
            if (c >= 3 && c <= 6) begin
                n_checks++;
                if (ARdData !== wd(c - 3)) begin
                    n_fail++;
                    $display("FAIL rd_data[c%0d]: got %h, required %h", c, ARdData, wd(c - 3));
                end
            end
            n_checks++;
            if ({ADone, ABusy} !== {c == 8, c <= 7}) begin
                n_fail++;
                $display("FAIL rd_status[c%0d]: got %b, required %b", c, {ADone, ABusy},
                         {c == 8, c <= 7});
            end
            step();
        end
        ARdRdy = 1'b0;
    endtask

    task automatic test_read_backpressure();
        int  n_iss;
        int  n_pop;
        int  outstanding;
        bit  done;
        do_write(13'h0040, 6, 10);
        n_iss = 0; n_pop = 0; done = 1'b0;
        ACmdReq = 1'b1; ACmdAddr = 13'h0040; ACmdLen = 8'd6; ACmdWr = 1'b0;
        step();
        ACmdReq = 1'b0;
        for (int cyc = 0; cyc < 80 && !done; cyc++) begin
            ARdRdy = (cyc % 3 == 0);
            sample();
            outstanding = n_iss - n_pop;
            n_checks++;
            if (outstanding > 2) begin
                n_fail++; $display("FAIL bp_occupancy[%0d]: got %0d, required <=2", cyc, outstanding);
            end
            n_checks++;
            if (RRdEn && RWrEn) begin
                n_fail++; $display("FAIL bp_strobes[%0d]: got both RRdEn and RWrEn, required one", cyc);
            end
            if (outstanding == 2 && !(ARdVld && ARdRdy)) begin
                n_checks++;
                if (RRdEn !== 1'b0) begin
                    n_fail++; $display("FAIL bp_stall[%0d]: got RRdEn=%b, required 0", cyc, RRdEn);
                end
            end
            if (RRdEn) begin
                n_checks++;
                if (RAddr !== 13'(64 + n_iss)) begin
                    n_fail++;
                    $display("FAIL bp_addr[%0d]: got %h, required %h", n_iss, RAddr, 13'(64 + n_iss));
                end
                n_iss++;
            end
            if (ARdVld && ARdRdy) begin
                n_checks++;
                if (ARdData !== wd(10 + n_pop)) begin
                    n_fail++;
                    $display("FAIL bp_data[%0d]: got %h, required %h", n_pop, ARdData, wd(10 + n_pop));
                end
                n_pop++;
            end
            if (ADone) done = 1'b1;
            step();
        end
        ARdRdy = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++; $display("FAIL bp_done: got no ADone, required ADone within 80 cycles");
        end
        n_checks++;
        if (n_iss != 6 || n_pop != 6) begin
            n_fail++; $display("FAIL bp_counts: got %0d reads %0d pops, required 6 and 6", n_iss, n_pop);
        end
    endtask

    task automatic test_wrap_and_zero();
        logic [CAddrLen-1:0] exp_addr [4];
        exp_addr = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001};
        ACmdReq = 1'b1; ACmdAddr = 13'h1FFE; ACmdLen = 8'd4; ACmdWr = 1'b1;
        step();
        ACmdReq = 1'b0;
        for (int i = 0; i < 4; i++) begin
            AWrVld = 1'b1; AWrData = wd(20 + i);
            sample();
            n_checks++;
            if (RWrEn !== 1'b1 || RAddr !== exp_addr[i]) begin
                n_fail++;
                $display("FAIL wrap_addr[%0d]: got en=%b addr=%h, required en=1 addr=%h", i, RWrEn,
                         RAddr, exp_addr[i]);
            end
            step();
        end
        AWrVld = 1'b0;
        sample();
        n_checks++;
        if (ADone !== 1'b1) begin
            n_fail++; $display("FAIL wrap_done: got %b, required 1", ADone);
        end
        step();
        // Zero-length command: ack, then ADone, with no RAM strobe.
        ACmdReq = 1'b1; ACmdAddr = 13'h0123; ACmdLen = 8'd0; ACmdWr = 1'b0;
        sample();
        n_checks++;
        if ({ACmdAck, RWrEn, RRdEn} !== 3'b100) begin
            n_fail++; $display("FAIL zero_ack: got %b, required 100", {ACmdAck, RWrEn, RRdEn});
        end
        step();
        ACmdReq = 1'b0;
        sample();
        n_checks++;
        if ({ADone, ABusy, RWrEn, RRdEn} !== 4'b1000) begin
            n_fail++;
            $display("FAIL zero_done: got %b, required 1000", {ADone, ABusy, RWrEn, RRdEn});
        end
        step();
        sample();
        n_checks++;
        if ({ADone, RWrEn, RRdEn} !== 3'b000) begin
            n_fail++; $display("FAIL zero_after: got %b, required 000", {ADone, RWrEn, RRdEn});
        end
        step();
    endtask

    task automatic test_reset_mid_read();
        bit seen;
        ARdRdy = 1'b0;
        ACmdReq = 1'b1; ACmdAddr = 13'h0040; ACmdLen = 8'd6; ACmdWr = 1'b0;
        step();
        ACmdReq = 1'b0;
        repeat (3) step();
        AResetH = 1'b1;
        step();
        AResetH = 1'b0;
        sample();
        n_checks++;
        if ({ACmdAck, ABusy, ADone, ARdVld, AWrRdy, RWrEn, RRdEn} !== 7'b0) begin
            n_fail++;
            $display("FAIL midrst_flags: got %b, required 0000000",
                     {ACmdAck, ABusy, ADone, ARdVld, AWrRdy, RWrEn, RRdEn});
        end
        n_checks++;
        if (RAddr !== '0 || ARdData !== '0) begin
            n_fail++; $display("FAIL midrst_bus: got addr=%h data=%h, required 0", RAddr, ARdData);
        end
        step();
        for (int c = 0; c < 4; c++) begin
            ARdRdy = 1'b1;
            sample();
            n_checks++;
            if ({ADone, ARdVld, RRdEn} !== 3'b000) begin
                n_fail++; $display("FAIL midrst_quiet[%0d]: got %b, required 000", c,
                                   {ADone, ARdVld, RRdEn});
            end
            step();
        end
        // A fresh read runs normally after the abandoned one.
        ACmdReq = 1'b1; ACmdAddr = 13'h0010; ACmdLen = 8'd2; ACmdWr = 1'b0;
        sample();
        n_checks++;
        if (ACmdAck !== 1'b1) begin
            n_fail++; $display("FAIL midrst_ack: got %b, required 1", ACmdAck);
        end
        step();
        ACmdReq = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            sample();
            n_checks++;
            if (RRdEn !== (c <= 2) || ARdVld !== (c >= 3)) begin
                n_fail++; $display("FAIL midrst_rd[c%0d]: got rd=%b vld=%b", c, RRdEn, ARdVld);
            end
            if (c >= 3) begin
                n_checks++;
                if (ARdData !== wd(c - 3)) begin
                    n_fail++;
                    $display("FAIL midrst_data[c%0d]: got %h, required %h", c, ARdData, wd(c - 3));
                end
            end
            step();
        end
        wait_done(seen);
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL midrst_done: got no ADone, required ADone");
        end
        ARdRdy = 1'b0;
    endtask

    task automatic test_clock_enable();
        ACmdReq = 1'b1; ACmdAddr = 13'h0080; ACmdLen = 8'd2; ACmdWr = 1'b1;
        step();
        ACmdReq = 1'b0;
        AWrVld = 1'b1; AWrData = wd(30);
        sample();
        n_checks++;
        if (RWrEn !== 1'b1 || RAddr !== 13'h0080) begin
            n_fail++; $display("FAIL ce_first: got en=%b addr=%h, required 1 0080", RWrEn, RAddr);
        end
        step();
        AClkHEn = 1'b0; AWrData = wd(31);
        sample();
        n_checks++;
        if ({RWrEn, AWrRdy} !== 2'b00 || RAddr !== 13'h0081) begin
            n_fail++;
            $display("FAIL ce_hold: got en=%b rdy=%b addr=%h, required 0 0 0081", RWrEn, AWrRdy,
                     RAddr);
        end
        step();
        AClkHEn = 1'b1;
        sample();
        n_checks++;
        if (RWrEn !== 1'b1 || RAddr !== 13'h0081) begin
            n_fail++; $display("FAIL ce_resume: got en=%b addr=%h, required 1 0081", RWrEn, RAddr);
        end
        step();
        AWrVld = 1'b0;
        sample();
        n_checks++;
        if (ADone !== 1'b1) begin
            n_fail++; $display("FAIL ce_done: got %b, required 1", ADone);
        end
        n_checks++;
        if (ram[13'h0081] !== wd(31)) begin
            n_fail++; $display("FAIL ce_ram: got %h, required %h", ram[13'h0081], wd(31));
        end
        step();
    endtask

`ifdef RAM_BURST_MASTER_CSUM_EN
    task automatic test_csum();
        bit seen;
        ACmdReq = 1'b1; ACmdAddr = 13'h0020; ACmdLen = 8'd4; ACmdWr = 1'b1;
        step();
        ACmdReq = 1'b0;
        AWrVld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            AWrData = CDataLen'(1) << i;
            step();
        end
        AWrVld = 1'b0;
        step();
        sample();
        n_checks++;
        if (ACsum !== 128'hF) begin
            n_fail++; $display("FAIL csum_write: got %h, required f", ACsum);
        end
        step();
        ARdRdy = 1'b1;
        ACmdReq = 1'b1; ACmdAddr = 13'h0020; ACmdLen = 8'd3; ACmdWr = 1'b0;
        step();
        ACmdReq = 1'b0;
        wait_done(seen);
        sample();
        n_checks++;
        if (!seen || ACsum !== 128'h7) begin
            n_fail++; $display("FAIL csum_read: got done=%b sum=%h, required 1 7", seen, ACsum);
        end
        ARdRdy = 1'b0;
        step();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_write_burst();
        test_read_burst();
        test_read_backpressure();
        test_wrap_and_zero();
        test_reset_mid_read();
        test_clock_enable();
`ifdef RAM_BURST_MASTER_CSUM_EN
        test_csum();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
